// File: rtl/ntt4_frame_loader.sv
// ntt4_frame_loader: serial-to-frame loader for the 4-point NTT network.
// Reduces samples mod the frame modulus and ping-pongs two frame banks.
module ntt4_frame_loader #(
   parameter int DATA_W = 8,
   parameter bit BITREV = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_last,
   input  logic [DATA_W-1:0]     mod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DATA_W-1:0]   out_data,
   output logic [DATA_W-1:0]     out_mod,
   output logic                  frame_err
);

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_st_t;

   bank_st_t          st_q [2];
   bank_st_t          st_d [2];
   logic [DATA_W-1:0] mem_q [2][4];
   logic [DATA_W-1:0] bmod_q [2];

   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] wr_idx_q, wr_idx_d;
   logic       in_ready_q, in_ready_d;
   logic       err_q, err_d;

   logic              accept;
   logic              handshake;
   logic              last_slot;
   logic              bad_frame;
   logic [DATA_W-1:0] eff_mod;
   logic [DATA_W-1:0] red;
   logic [1:0]        slot;

   assign accept    = in_valid & in_ready_q;
   assign out_valid = (st_q[rd_bank_q] == FULL);
   assign handshake = out_valid & out_ready;
   assign in_ready  = in_ready_q;
   assign frame_err = err_q;

   // The modulus of the first sample is taken live; later samples
   // use the value latched for the bank, so mid-frame changes are ignored.
   assign eff_mod = (wr_idx_q == 2'd0) ? mod : bmod_q[wr_bank_q];

   // A zero modulus passes data through raw; the frame is dropped later.
   assign red = (eff_mod == '0) ? in_data : in_data % eff_mod;

   assign slot = BITREV ? {wr_idx_q[0], wr_idx_q[1]} : wr_idx_q;

   assign last_slot = (wr_idx_q == 2'd3);
   assign bad_frame = (in_last != last_slot) ||
                      (last_slot && eff_mod == '0);

   // Next-state for bank states, pointers, ready and error pulse.
   always_comb begin
      st_d[0]    = st_q[0];
      st_d[1]    = st_q[1];
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_idx_d   = wr_idx_q;
      err_d      = 1'b0;
      if (handshake) begin
         st_d[rd_bank_q] = EMPTY;
         rd_bank_d       = ~rd_bank_q;
      end
      if (accept) begin
         if (bad_frame) begin
            st_d[wr_bank_q] = EMPTY;
            wr_idx_d        = 2'd0;
            err_d           = 1'b1;
         end else if (last_slot) begin
            st_d[wr_bank_q] = FULL;
            wr_bank_d       = ~wr_bank_q;
            wr_idx_d        = 2'd0;
         end else begin
            st_d[wr_bank_q] = FILLING;
            wr_idx_d        = wr_idx_q + 2'd1;
         end
      end
      in_ready_d = (st_d[wr_bank_d] != FULL);
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q[0]    <= EMPTY;
         st_q[1]    <= EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_idx_q   <= 2'd0;
         in_ready_q <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         st_q[0]    <= st_d[0];
         st_q[1]    <= st_d[1];
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_idx_q   <= wr_idx_d;
         in_ready_q <= in_ready_d;
         err_q      <= err_d;
      end
   end

   // Bank storage: reduced samples written to their output slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            bmod_q[b] <= '0;
            for (int s = 0; s < 4; s++) begin
               mem_q[b][s] <= '0;
            end
         end
      end else if (accept) begin
         mem_q[wr_bank_q][slot] <= red;
         if (wr_idx_q == 2'd0) begin
            bmod_q[wr_bank_q] <= mod;
         end
      end
   end

   // Present the read bank as one parallel frame.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < 4; i++) begin
         out_data[i*DATA_W +: DATA_W] = mem_q[rd_bank_q][i];
      end
      out_mod = bmod_q[rd_bank_q];
   end

endmodule

// File: tb/tb_ntt4_frame_loader.sv
// tb_ntt4_frame_loader: directed stimulus with a frame scoreboard.
// A second instance checks natural slot order.
module tb_ntt4_frame_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic [7:0]  mod;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_mod;
   logic        frame_err;

   logic        in_ready0;
   logic        out_valid0;
   logic [31:0] out_data0;
   logic [7:0]  out_mod0;
   logic        frame_err0;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  m;
   } frame_t;

   frame_t      q[$];
   int          checks = 0;
   int          errors = 0;
   int          err_seen = 0;
   int          exp_err = 0;
   logic [31:0] hold;

   ntt4_frame_loader #(.DATA_W(8), .BITREV(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .mod(mod),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_mod(out_mod),
      .frame_err(frame_err)
   );

   ntt4_frame_loader #(.DATA_W(8), .BITREV(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_last(in_last), .mod(mod),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_mod(out_mod0),
      .frame_err(frame_err0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_frame(
      input logic [7:0] s0, s1, s2, s3, m,
      input bit br);
      logic [7:0] r [4];
      logic [31:0] f;
      r[0] = s0 % m;
      r[1] = s1 % m;
      r[2] = s2 % m;
      r[3] = s3 % m;
      if (br) f = {r[3], r[1], r[2], r[0]};
      else    f = {r[3], r[2], r[1], r[0]};
      return f;
   endfunction

   // Scoreboard: compare each handshaked frame with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            frame_t e;
            e = q.pop_front();
            chk("sb_data", 64'(out_data), 64'(e.d));
            chk("sb_mod", 64'(out_mod), 64'(e.m));
         end
      end
   end

   // Count error pulses.
   always @(negedge clk) begin
      if (rst_n && frame_err) err_seen++;
   end

   task automatic push(input logic [7:0] d,
                       input logic l,
                       input logic [7:0] m);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      mod      = m;
      while (!in_ready && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      chk("push_wait", 64'(g < 200), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] s0, s1, s2, s3,
                             input logic [7:0] m0, m1,
                             input int n, input int last_at);
      logic [7:0] s [4];
      frame_t e;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      if (n == 4 && last_at == 3 && m0 != 0) begin
         e.d = exp_frame(s0, s1, s2, s3, m0, 1'b1);
         e.m = m0;
         q.push_back(e);
      end else begin
         exp_err++;
      end
      for (int i = 0; i < n; i++) begin
         push(s[i], 1'(i == last_at), (i == 0) ? m0 : m1);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q.size() != 0 && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("drain_q", 64'(q.size()), 64'd0);
      chk("err_cnt", 64'(err_seen), 64'(exp_err));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      mod       = 8'd5;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_mod", 64'(out_mod), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame and one-cycle latency.
      out_ready = 1'b1;
      send_frame(1, 2, 3, 4, 5, 5, 4, 3);
      chk("t1_latency", 64'(out_valid), 64'd1);
      chk("t1_data", 64'(out_data), 64'h04020301);
      drain();

      // Reduction, both slot orders.
      send_frame(7, 9, 12, 5, 5, 5, 4, 3);
      chk("t2_valid0", 64'(out_valid0), 64'd1);
      chk("t2_nat_data", 64'(out_data0), 64'h00020402);
      chk("t2_nat_mod", 64'(out_mod0), 64'd5);
      drain();

      // Backpressure: two banks held, third frame waits.
      out_ready = 1'b0;
      send_frame(20, 21, 22, 23, 9, 9, 4, 3);
      chk("t3_ready_one", 64'(in_ready), 64'd1);
      send_frame(30, 31, 32, 33, 11, 11, 4, 3);
      chk("t3_ready_low", 64'(in_ready), 64'd0);
      chk("t3_valid", 64'(out_valid), 64'd1);
      hold = out_data;
      repeat (3) @(posedge clk);
      #1;
      chk("t3_stable", 64'(out_data), 64'(hold));
      chk("t3_ready_held", 64'(in_ready), 64'd0);
      fork
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         send_frame(40, 41, 42, 43, 13, 13, 4, 3);
      join
      drain();

      // Framing errors.
      send_frame(1, 2, 0, 0, 5, 5, 2, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_err_early", 64'(err_seen), 64'(exp_err));
      chk("t4_no_valid", 64'(out_valid), 64'd0);
      send_frame(1, 2, 3, 4, 5, 5, 4, -1);
      send_frame(10, 11, 12, 13, 7, 7, 4, 3);
      chk("t4_data", 64'(out_data), 64'h06040503);
      drain();

      // Zero modulus and mid-frame modulus change.
      send_frame(1, 2, 3, 4, 0, 0, 4, 3);
      repeat (2) @(posedge clk);
      #1;
      chk("t5_zero_err", 64'(err_seen), 64'(exp_err));
      chk("t5_zero_nv", 64'(out_valid), 64'd0);
      send_frame(6, 7, 8, 9, 5, 3, 4, 3);
      drain();

      // Reset with a full frame pending and a partial frame.
      out_ready = 1'b0;
      send_frame(50, 51, 52, 53, 7, 7, 4, 3);
      push(60, 1'b0, 8'd7);
      push(61, 1'b0, 8'd7);
      @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_out_data", 64'(out_data), 64'd0);
      chk("t6_out_mod", 64'(out_mod), 64'd0);
      chk("t6_frame_err", 64'(frame_err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_frame(100, 101, 102, 103, 10, 10, 4, 3);
      chk("t6_data", 64'(out_data), 64'h03010200);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
